// File: rtl/wb_stage_sq.sv
// Writeback stage: registers the retiring instruction's register-file write
// and EFLAGS update, and keeps stores in order in a circular store queue that
// drains to data memory over a valid/ready handshake.
module wb_stage_sq #(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int RW       = 3,
    parameter int SQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    input  logic [AW-1:0]               in_addr,
    input  logic [RW-1:0]               in_dr,
    input  logic                        in_is_mem,
    input  logic [1:0]                  in_op,
    input  logic                        in_of,
    input  logic                        in_af,
    input  logic                        in_cf,
    output logic                        reg_write,
    output logic [RW-1:0]               dr,
    output logic [DW-1:0]               dr_data,
    output logic                        flags_valid,
    output logic [31:0]                 flags,
    output logic [31:0]                 flags_mask,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_data,
    output logic [$clog2(SQ_DEPTH):0]   sq_count,
    output logic                        sq_empty
);

    localparam int PW = $clog2(SQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] ARITH_MASK = 32'h0000_08D5;

    // PF is set when the low byte holds an even number of ones.
    function automatic logic even_parity8(input logic [7:0] b);
        return ~(^b);
    endfunction

    logic [CW-1:0] count_r;
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [AW-1:0] addr_mem_r [SQ_DEPTH];
    logic [DW-1:0] data_mem_r [SQ_DEPTH];

    logic          full_s;
    logic          empty_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          arith_s;
    logic [31:0]   flags_next_s;

    // Back-pressure and queue status depend only on the registered count.
    assign full_s    = (count_r == CW'(SQ_DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign in_ready  = ~full_s;
    assign sq_empty  = empty_s;
    assign sq_count  = count_r;
    assign mem_valid = ~empty_s;
    assign mem_addr  = empty_s ? {AW{1'b0}} : addr_mem_r[head_r];
    assign mem_data  = empty_s ? {DW{1'b0}} : data_mem_r[head_r];

    assign accept_s = in_valid & ~full_s;
    assign push_s   = accept_s & in_is_mem;
    assign pop_s    = ~empty_s & mem_ready;
    assign arith_s  = (in_op == 2'b00);

    // New EFLAGS image; CF/AF/OF only survive for arithmetic ops.
    always_comb begin
        flags_next_s        = 32'h0000_0000;
        flags_next_s[0]     = in_cf & arith_s;
        flags_next_s[2]     = even_parity8(in_data[7:0]);
        flags_next_s[4]     = in_af & arith_s;
        flags_next_s[6]     = (in_data == {DW{1'b0}});
        flags_next_s[7]     = in_data[DW-1];
        flags_next_s[11]    = in_of & arith_s;
    end

    // Register-write and flag outputs: strobes pulse once per accept, data holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write   <= 1'b0;
            dr          <= {RW{1'b0}};
            dr_data     <= {DW{1'b0}};
            flags_valid <= 1'b0;
            flags       <= 32'h0000_0000;
            flags_mask  <= 32'h0000_0000;
        end else if (accept_s) begin
            reg_write   <= ~in_is_mem & (in_op != 2'b11);
            dr          <= in_dr;
            dr_data     <= in_data;
            flags_valid <= ~in_op[1];
            flags       <= flags_next_s;
            flags_mask  <= in_op[1] ? 32'h0000_0000 : ARITH_MASK;
        end else begin
            reg_write   <= 1'b0;
            flags_valid <= 1'b0;
        end
    end

    // Store queue storage, written at the tail on each store accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                addr_mem_r[i] <= {AW{1'b0}};
                data_mem_r[i] <= {DW{1'b0}};
            end
        end else if (push_s) begin
            addr_mem_r[tail_r] <= in_addr;
            data_mem_r[tail_r] <= in_data;
        end else begin
            addr_mem_r[tail_r] <= addr_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage_sq.sv
// Self-checking bench for wb_stage_sq: directed cases with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_wb_stage_sq;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [31:0] in_addr = 32'h0;
    logic [2:0]  in_dr = 3'h0;
    logic        in_is_mem = 1'b0;
    logic [1:0]  in_op = 2'b00;
    logic        in_of = 1'b0;
    logic        in_af = 1'b0;
    logic        in_cf = 1'b0;
    logic        reg_write;
    logic [2:0]  dr;
    logic [31:0] dr_data;
    logic        flags_valid;
    logic [31:0] flags;
    logic [31:0] flags_mask;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [2:0]  sq_count;
    logic        sq_empty;

    wb_stage_sq #(.DW(32), .AW(32), .RW(3), .SQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_dr(in_dr), .in_is_mem(in_is_mem),
        .in_op(in_op), .in_of(in_of), .in_af(in_af), .in_cf(in_cf),
        .reg_write(reg_write), .dr(dr), .dr_data(dr_data),
        .flags_valid(flags_valid), .flags(flags), .flags_mask(flags_mask),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .sq_count(sq_count), .sq_empty(sq_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] aq[$];
    logic [31:0] dq[$];
    logic        e_rw = 1'b0;
    logic [2:0]  e_dr = 3'h0;
    logic [31:0] e_dd = 32'h0;
    logic        e_fv = 1'b0;
    logic [31:0] e_fl = 32'h0;
    logic [31:0] e_fm = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_flags(input logic [1:0] op, input logic [31:0] d,
                                                input logic cf, input logic af, input logic of);
        int f = 0;
        if (op == 2'd0 && cf) f += 1;
        if ($countones(d[7:0]) % 2 == 0) f += 4;
        if (op == 2'd0 && af) f += 16;
        if (d == 32'd0) f += 64;
        if (d[31]) f += 128;
        if (op == 2'd0 && of) f += 2048;
        return 32'(f);
    endfunction

    task automatic compare_all();
        chk("in_ready", 64'(in_ready), 64'(aq.size() < DEPTH));
        chk("sq_count", 64'(sq_count), 64'(aq.size()));
        chk("sq_empty", 64'(sq_empty), 64'(aq.size() == 0));
        chk("mem_valid", 64'(mem_valid), 64'(aq.size() != 0));
        if (aq.size() != 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(aq[0]));
            chk("mem_data", 64'(mem_data), 64'(dq[0]));
        end
        chk("reg_write", 64'(reg_write), 64'(e_rw));
        chk("flags_valid", 64'(flags_valid), 64'(e_fv));
        chk("dr", 64'(dr), 64'(e_dr));
        chk("dr_data", 64'(dr_data), 64'(e_dd));
        chk("flags", 64'(flags), 64'(e_fl));
        chk("flags_mask", 64'(flags_mask), 64'(e_fm));
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic mem,
                         input logic [31:0] d, input logic [31:0] a, input logic [2:0] r,
                         input logic cf, input logic af, input logic of, input logic mr);
        in_valid = v; in_op = op; in_is_mem = mem; in_data = d; in_addr = a;
        in_dr = r; in_cf = cf; in_af = af; in_of = of; mem_ready = mr;
    endtask

    // One clock: model advances from the pre-edge inputs, then outputs are compared.
    task automatic step();
        bit acc;
        bit pop;
        acc = in_valid && (aq.size() < DEPTH);
        pop = (aq.size() > 0) && mem_ready;
        @(posedge clk);
        if (pop) begin
            void'(aq.pop_front());
            void'(dq.pop_front());
        end
        if (acc && in_is_mem) begin
            aq.push_back(in_addr);
            dq.push_back(in_data);
        end
        if (acc) begin
            e_rw = !in_is_mem && (in_op != 2'b11);
            e_dr = in_dr;
            e_dd = in_data;
            e_fv = (in_op < 2'd2);
            e_fm = e_fv ? 32'h0000_08D5 : 32'h0;
            e_fl = model_flags(in_op, in_data, in_cf, in_af, in_of);
        end else begin
            e_rw = 1'b0;
            e_fv = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic model_reset();
        aq.delete(); dq.delete();
        e_rw = 1'b0; e_dr = 3'h0; e_dd = 32'h0; e_fv = 1'b0; e_fl = 32'h0; e_fm = 32'h0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_flags_valid", 64'(flags_valid), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_sq_empty", 64'(sq_empty), 64'd1);
        chk("rst_sq_count", 64'(sq_count), 64'd0);
        chk("rst_dr_data", 64'(dr_data), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_flags_mask", 64'(flags_mask), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Arithmetic op on zero data
        drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk("arith_flags_lit", 64'(flags), 64'h845);
        chk("arith_mask_lit", 64'(flags_mask), 64'h8D5);
        chk("arith_rw_lit", 64'(reg_write), 64'd1);

        // Logic op
        drive(1'b1, 2'b01, 1'b0, 32'h8000_0003, 32'h0, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("logic_flags_lit", 64'(flags), 64'h84);
        chk("logic_fv_lit", 64'(flags_valid), 64'd1);

        // Move op
        drive(1'b1, 2'b10, 1'b0, 32'h1234, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("move_fv_lit", 64'(flags_valid), 64'd0);
        chk("move_mask_lit", 64'(flags_mask), 64'd0);

        // No-op
        drive(1'b1, 2'b11, 1'b0, 32'h55, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("nop_rw_lit", 64'(reg_write), 64'd0);

        // Idle cycle: strobes drop
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // Fill the queue with the memory port stalled
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 2'b10, 1'b1, 32'hA000 + 32'(i), 32'h100 + 32'(4 * i), 3'd1,
                  1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("full_ready_lit", 64'(in_ready), 64'd0);
        chk("full_count_lit", 64'(sq_count), 64'd4);
        chk("full_head_lit", 64'(mem_addr), 64'h100);

        // Held request while full must not be accepted
        drive(1'b1, 2'b00, 1'b1, 32'hDEAD, 32'h200, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        chk("held_head_lit", 64'(mem_addr), 64'h100);
        chk("held_count_lit", 64'(sq_count), 64'd4);

        // Drain two entries
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step();
        chk("drain2_count_lit", 64'(sq_count), 64'd2);
        chk("drain2_head_lit", 64'(mem_addr), 64'h108);

        // Simultaneous push and pop, wrapping the tail pointer
        drive(1'b1, 2'b00, 1'b1, 32'hBEEF, 32'h110, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        step();
        chk("pushpop_count_lit", 64'(sq_count), 64'd2);
        chk("store_rw_lit", 64'(reg_write), 64'd0);
        chk("store_fv_lit", 64'(flags_valid), 64'd1);
        chk("pushpop_head_lit", 64'(mem_addr), 64'h10C);

        // Drain everything
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        chk("drained_empty_lit", 64'(sq_empty), 64'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'($urandom_range(0, 255));
                default: d = $urandom;
            endcase
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) == 0), d, $urandom, 3'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 2) != 0));
            step();
        end

        // Reset mid-stream with three stores queued
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (DEPTH + 1) step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 1'b1, 32'h7700 + 32'(i), 32'h300 + 32'(4 * i), 3'd1,
                  1'b1, 1'b0, 1'b0, 1'b0);
            step();
        end
        chk("pre_rst_count_lit", 64'(sq_count), 64'd3);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        drive(1'b1, 2'b10, 1'b1, 32'h4242, 32'hABC, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst_head_lit", 64'(mem_addr), 64'hABC);
        chk("post_rst_count_lit", 64'(sq_count), 64'd1);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
